// File: rtl/counter_readout.sv
// Snapshot reader for the banked event counters: latches all counters on a trigger,
// streams per-counter deltas as a header plus data words, and issues counter clear pulses.
module counter_readout #(
    parameter int unsigned NCOUNTERS  = 3,
    parameter int unsigned WIDTH      = 48,
    parameter int unsigned WORD       = 16,
    parameter int unsigned CLR_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NCOUNTERS*WIDTH-1:0]   counters,
    output logic [NCOUNTERS-1:0]         load,
    input  logic                         trigger,
    input  logic                         clear_req,
    output logic [WORD-1:0]              m_data,
    output logic                         m_valid,
    output logic                         m_last,
    input  logic                         m_ready,
    output logic                         busy
);

    localparam int unsigned WPC = WIDTH / WORD;
    localparam int unsigned NW  = NCOUNTERS * WPC;
    localparam int unsigned CW  = (NCOUNTERS > 1) ? $clog2(NCOUNTERS) : 1;
    localparam int unsigned WW  = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int unsigned TW  = (CLR_CYCLES > 0) ? $clog2(CLR_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StHdr, StData, StClr} state_e;

    state_e                           state_q;
    logic [NCOUNTERS-1:0][WIDTH-1:0]  prev_q;
    logic [NCOUNTERS-1:0][WIDTH-1:0]  snap_q;
    logic [7:0]                       seq_q;
    logic [7:0]                       dropped_q;
    logic [CW-1:0]                    cidx_q;
    logic [WW-1:0]                    widx_q;
    logic [TW-1:0]                    clr_cnt_q;

    logic [7:0]      dropped_inc;
    logic            last_word;
    logic [CW-1:0]   nxt_cidx;
    logic [WW-1:0]   nxt_widx;
    logic            nxt_last;
    logic [WORD-1:0] hdr_word;

    // Most-significant word of each counter goes out first.
    function automatic logic [WORD-1:0] pick(input logic [NCOUNTERS-1:0][WIDTH-1:0] s,
                                             input logic [CW-1:0] c,
                                             input logic [WW-1:0] w);
        int unsigned base;
        base = (WPC - 1 - 32'(w)) * WORD;
        return s[c][base +: WORD];
    endfunction

    always_comb begin
        dropped_inc = (dropped_q == 8'hFF) ? dropped_q : dropped_q + 8'd1;
        last_word   = (cidx_q == CW'(NCOUNTERS - 1)) && (widx_q == WW'(WPC - 1));
        nxt_cidx    = cidx_q;
        nxt_widx    = widx_q + WW'(1);
        if (widx_q == WW'(WPC - 1)) begin
            nxt_cidx = cidx_q + CW'(1);
            nxt_widx = '0;
        end
        nxt_last        = (nxt_cidx == CW'(NCOUNTERS - 1)) && (nxt_widx == WW'(WPC - 1));
        hdr_word        = '0;
        hdr_word[15:0]  = {seq_q, dropped_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            prev_q    <= '0;
            snap_q    <= '0;
            seq_q     <= '0;
            dropped_q <= '0;
            cidx_q    <= '0;
            widx_q    <= '0;
            clr_cnt_q <= '0;
            load      <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            load <= '0;
            unique case (state_q)
                StIdle: begin
                    if (clear_req) begin
                        load      <= '1;
                        prev_q    <= '0;
                        clr_cnt_q <= TW'(CLR_CYCLES);
                        state_q   <= StClr;
                        if (trigger) dropped_q <= dropped_inc;
                    end else if (trigger) begin
                        for (int unsigned i = 0; i < NCOUNTERS; i++) begin
                            snap_q[i] <= counters[i*WIDTH +: WIDTH] - prev_q[i];
                            prev_q[i] <= counters[i*WIDTH +: WIDTH];
                        end
                        m_data  <= hdr_word;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        state_q <= StHdr;
                    end
                end
                StHdr: begin
                    if (m_ready) begin
                        // A trigger in the accepting cycle survives the clear.
                        dropped_q <= trigger ? 8'd1 : 8'd0;
                        cidx_q    <= '0;
                        widx_q    <= '0;
                        m_data    <= pick(snap_q, '0, '0);
                        m_last    <= (NW == 1);
                        state_q   <= StData;
                    end else if (trigger) begin
                        dropped_q <= dropped_inc;
                    end
                end
                StData: begin
                    if (trigger) dropped_q <= dropped_inc;
                    if (m_ready) begin
                        if (last_word) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            seq_q   <= seq_q + 8'd1;
                            state_q <= StIdle;
                        end else begin
                            cidx_q <= nxt_cidx;
                            widx_q <= nxt_widx;
                            m_data <= pick(snap_q, nxt_cidx, nxt_widx);
                            m_last <= nxt_last;
                        end
                    end
                end
                StClr: begin
                    if (trigger) dropped_q <= dropped_inc;
                    if (clr_cnt_q == '0) state_q <= StIdle;
                    else                 clr_cnt_q <= clr_cnt_q - TW'(1);
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

endmodule
